// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for the skid-buffered pipeline stage
// Contents: pipe_state_e (EMPTY/BUSY/FULL), PIPE_DATA_W, PIPE_CNT_W
package pipe_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CNT_W  = 16;
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: counter that increments once per cycle with inc high and sticks at all-ones
// Ports: clk, rst (sync, active-high) | inc -> one step per cycle | count -> current value
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk)
        if (rst)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage with a main and a skid register, flush, optional perf counters
// Ports: clk, rst (sync, active-high), flush (drops held beats and any coinciding input)
//        upstream: in_valid, in_ready (flopped), in_data
//        downstream: out_valid, out_ready, out_data (flopped from the main register)
//        PIPE_PERF_CNT_EN only: stall_cnt (out_valid & ~out_ready cycles), bubble_cnt (~out_valid cycles)
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic [DATA_W-1:0] out_data
);
    if (DATA_W < 1 || CNT_W < 2) begin : g_bad_param
        $error("pipe_skid_stage: DATA_W must be >= 1 and CNT_W >= 2");
    end

    pipe_state_e       state, state_nxt;
    logic [DATA_W-1:0] skid;
    logic              in_fire, out_fire, ld_main, ld_skid, main_from_skid;

    assign in_fire   = in_valid & in_ready;
    assign out_valid = state != EMPTY;
    assign out_fire  = out_valid & out_ready;

    // Flush forces EMPTY and suppresses every load, which also discards a coinciding input fire.
    always_comb begin
        state_nxt      = state;
        ld_main        = 1'b0;
        ld_skid        = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                state_nxt = in_fire ? BUSY : EMPTY;
                ld_main   = in_fire;
            end
            BUSY: begin
                state_nxt = in_fire ? (out_fire ? BUSY : FULL) : (out_fire ? EMPTY : BUSY);
                ld_main   = in_fire & out_fire;
                ld_skid   = in_fire & ~out_fire;
            end
            FULL: begin
                state_nxt      = out_fire ? BUSY : FULL;
                ld_main        = out_fire;
                main_from_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            ld_main   = 1'b0;
            ld_skid   = 1'b0;
        end
    end

    // in_ready is the registered decode of the next state; held low through reset.
    always_ff @(posedge clk)
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            out_data <= '0;
            skid     <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= state_nxt != FULL;
            if (flush) begin
                out_data <= '0;
                skid     <= '0;
            end else begin
                if (ld_main)
                    out_data <= main_from_skid ? skid : in_data;
                if (ld_skid)
                    skid <= in_data;
            end
        end

`ifdef PIPE_PERF_CNT_EN
    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );
    pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (~out_valid),
        .count(bubble_cnt)
    );
`endif
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed self-checking bench for pipe_skid_stage (counter checks when PIPE_PERF_CNT_EN is defined)
module tb_pipe_skid_stage;
    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] stall_cnt, bubble_cnt;
`endif
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = 32'hA5A5_A5A5;
        tick();
        chk("first_out_valid", {31'b0, out_valid}, 32'd1);
        chk("first_out_data", out_data, 32'hA5A5_A5A5);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("drain_empty", {31'b0, out_valid}, 32'd0);

        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            chk($sformatf("stream_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stream_data_%0d", i), out_data, i);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
        tick();
        chk("bp_main1", out_data, 32'd1);
        in_data = 32'd2;
        tick();
        chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold1", out_data, 32'd1);
        in_data = 32'd3;
        tick();
        chk("bp_stable", out_data, 32'd1);
        chk("bp_still_full", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_out2", out_data, 32'd2);
        chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
        tick();
        chk("bp_out3", out_data, 32'd3);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        chk("fl_full", {31'b0, in_ready}, 32'd0);
        in_data = 32'h55; flush = 1'b1;
        tick();
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        chk("fl_data", out_data, 32'd0);
        flush = 1'b0; in_data = 32'h66;
        tick();
        in_data = 32'h55; flush = 1'b1;
        tick();
        chk("fl_busy_drop", {31'b0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_no_55", {31'b0, out_valid}, 32'd0);
        chk("fl_no_55_data", out_data, 32'd0);

`ifdef PIPE_PERF_CNT_EN
        rst = 1'b1; out_ready = 1'b0;
        tick();
        chk("cnt_rst_stall", {30'b0, stall_cnt}, 32'd0);
        chk("cnt_rst_bubble", {30'b0, bubble_cnt}, 32'd0);
        rst = 1'b0;
        tick(); tick();
        chk("cnt_bubble2", {30'b0, bubble_cnt}, 32'd2);
        chk("cnt_stall0", {30'b0, stall_cnt}, 32'd0);
        in_valid = 1'b1; in_data = 32'h7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_stall_sat", {30'b0, stall_cnt}, 32'd3);
        chk("cnt_bubble3", {30'b0, bubble_cnt}, 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("cnt_flush_stall", {30'b0, stall_cnt}, 32'd3);
        chk("cnt_flush_bubble", {30'b0, bubble_cnt}, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cnt_rst2_stall", {30'b0, stall_cnt}, 32'd0);
        chk("cnt_rst2_bubble", {30'b0, bubble_cnt}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
